ex_div_stage: RTL and testbench

Execute stage of the five-stage MIPS32 pipeline, fed by the ID/EX pipeline register, which carries the decoder's `aluop`/`alusel`/operand/destination outputs. It computes logic and shift results in the same cycle. It also runs DIV/DIVU on a 32-iteration radix-2 divider, asserting a stall request for the whole divide and writing HI/LO on completion. GPR results go to EX/MEM and back to ID as the EX forwarding path (`ex_wreg_i`/`ex_wd_i`/`ex_wdata_i`).

---
 rtl/ex_div_stage_pkg.sv | 40 ++++
 rtl/ex_div_stage_div_unit.sv | 104 ++++++++++
 rtl/ex_div_stage.sv | 92 +++++++++
 tb/tb_ex_div_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ex_div_stage_pkg.sv
// Shared opcodes, result classes and divider state encodings for the execute stage.
package ex_div_stage_pkg;

  localparam int ALU_OP_W  = 8;
  localparam int ALU_SEL_W = 3;

  localparam logic [5:0] EXE_DIV  = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_DIV   = 3'b101;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_stage_div_unit.sv
// 32-step restoring divider on a 65-bit {remainder,quotient} register with sign fix-up.
module div_unit
  import ex_div_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [64:0] r_rq, w_rq_nxt;
  logic [31:0] r_dvsr, w_dvsr_nxt;
  logic        r_neg_q, r_neg_r, w_neg_q_nxt, w_neg_r_nxt;
  logic [64:0] w_shl;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_shl  = r_rq << 1;
  assign w_ge   = (w_shl[64:32] >= {1'b0, r_dvsr});
  assign w_diff = w_shl[64:32] - {1'b0, r_dvsr};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rq_nxt    = r_rq;
    w_dvsr_nxt  = r_dvsr;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    case (r_state)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          if (op2_i == 32'd0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt = DIV_ON;
            w_rq_nxt    = {33'd0, cond_neg(op1_i, signed_i && op1_i[31])};
            w_dvsr_nxt  = cond_neg(op2_i, signed_i && op2_i[31]);
            w_neg_q_nxt = signed_i && (op1_i[31] ^ op2_i[31]);
            w_neg_r_nxt = signed_i && op1_i[31];
            w_cnt_nxt   = 6'd0;
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end
      DIV_BYZERO: begin
        w_state_nxt = DIV_END;
        w_rq_nxt    = 65'd0;
      end
      DIV_ON: begin
        // Trial subtraction; on success the freed LSB becomes the quotient bit.
        w_rq_nxt  = w_ge ? {w_diff, w_shl[31:1], 1'b1} : w_shl;
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == 6'd31) begin
          w_state_nxt = DIV_END;
        end else begin
          w_state_nxt = DIV_ON;
        end
      end
      DIV_END: w_state_nxt = DIV_FREE;
      default: w_state_nxt = DIV_FREE;
    endcase
    if (annul_i) begin
      w_state_nxt = DIV_FREE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_FREE;
      r_cnt   <= 6'd0;
      r_rq    <= 65'd0;
      r_dvsr  <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rq    <= w_rq_nxt;
      r_dvsr  <= w_dvsr_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
    end
  end

  always_comb begin
    ready_o = (r_state == DIV_END) && !annul_i;
    if (ready_o) begin
      result_o = {cond_neg(r_rq[63:32], r_neg_r), cond_neg(r_rq[31:0], r_neg_q)};
    end else begin
      result_o = 64'd0;
    end
  end

endmodule

// File: rtl/ex_div_stage.sv
// MIPS32 execute stage: combinational logic/shift results plus a stalling DIV/DIVU unit.
module ex_div_stage
  import ex_div_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [ALU_SEL_W-1:0] alusel_i,
  input  logic [31:0]          reg1_i,
  input  logic [31:0]          reg2_i,
  input  logic [4:0]           wd_i,
  input  logic                 wreg_i,
  input  logic                 annul_i,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 whilo_o,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o,
  output logic                 stallreq_o
);

  logic [31:0] w_logic, w_shift, w_wdata;
  logic [63:0] w_result;
  logic        w_is_div, w_start, w_signed, w_ready;

  assign w_is_div = (alusel_i == EXE_RES_DIV);
  assign w_start  = w_is_div && ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP));
  assign w_signed = (aluop_i == EXE_DIV_OP);

  always_comb begin
    case (aluop_i)
      EXE_OR_OP:  w_logic = reg1_i | reg2_i;
      EXE_AND_OP: w_logic = reg1_i & reg2_i;
      EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
      default:    w_logic = 32'd0;
    endcase
  end

  always_comb begin
    case (aluop_i)
      EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    w_shift = 32'd0;
    endcase
  end

  always_comb begin
    case (alusel_i)
      EXE_RES_LOGIC: w_wdata = w_logic;
      EXE_RES_SHIFT: w_wdata = w_shift;
      default:       w_wdata = 32'd0;
    endcase
  end

  div_unit u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_start),
    .signed_i (w_signed),
    .op1_i    (reg1_i),
    .op2_i    (reg2_i),
    .annul_i  (annul_i),
    .result_o (w_result),
    .ready_o  (w_ready)
  );

  // The divide op is held in ID/EX by the stall, so "start and not yet ready" covers IDLE, BYZERO and ON.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = NO_STOP;
    if (rst) begin
      stallreq_o = NO_STOP;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !w_is_div;
      wdata_o    = w_wdata;
      whilo_o    = w_ready;
      hi_o       = w_result[63:32];
      lo_o       = w_result[31:0];
      stallreq_o = (w_start && !w_ready && !annul_i) ? STOP : NO_STOP;
    end
  end

endmodule

// File: tb/tb_ex_div_stage.sv
// Directed bench for ex_div_stage: vector table for logic/shift, sequences for divides, annul and reset.
module tb_ex_div_stage;
  import ex_div_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ALU_OP_W-1:0]  aluop_i;
  logic [ALU_SEL_W-1:0] alusel_i;
  logic [31:0]          reg1_i, reg2_i;
  logic [4:0]           wd_i;
  logic                 wreg_i, annul_i;
  logic [4:0]           wd_o;
  logic                 wreg_o, whilo_o, stallreq_o;
  logic [31:0]          wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  ex_div_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    aluop_i  = EXE_NOP_OP;
    alusel_i = EXE_RES_NOP;
  endtask

  // Caller is at the start of a cycle; leaves at the start of the cycle after the result.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic scramble);
    int got_cyc = -1;
    int stalls  = 0;
    logic [31:0] lo_s = 32'd0, hi_s = 32'd0;
    logic wreg_s = 1'b1, stall_s = 1'b1;
    aluop_i  = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
    alusel_i = EXE_RES_DIV;
    reg1_i   = a;
    reg2_i   = b;
    wreg_i   = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (whilo_o) begin
        got_cyc = c;
        lo_s    = lo_o;
        hi_s    = hi_o;
        wreg_s  = wreg_o;
        stall_s = stallreq_o;
        break;
      end else if (stallreq_o) begin
        stalls++;
      end
      next_cycle();
      if (scramble && c == 5) begin
        reg1_i = 32'hDEAD_BEEF;
        reg2_i = 32'h0000_0003;
      end
    end
    chk({name, " result_cycle"}, got_cyc, exp_cyc);
    chk({name, " stall_cycles"}, stalls, exp_cyc);
    chk({name, " lo"}, lo_s, exp_lo);
    chk({name, " hi"}, hi_s, exp_hi);
    chk({name, " wreg_o"}, {31'd0, wreg_s}, 32'd0);
    chk({name, " stall_at_end"}, {31'd0, stall_s}, 32'd0);
    next_cycle();
    set_nop();
  endtask

  // Starts a DIVU 100/7, then at cycle 10 applies annul (use_rst=0) or rst (use_rst=1).
  task automatic abort_div(input string name, input logic use_rst);
    int pulses = 0;
    aluop_i  = EXE_DIVU_OP;
    alusel_i = EXE_RES_DIV;
    reg1_i   = 32'd100;
    reg2_i   = 32'd7;
    wd_i     = 5'd9;
    for (int c = 0; c < 10; c++) next_cycle();
    if (use_rst) rst = 1'b1;
    else annul_i = 1'b1;
    @(negedge clk);
    chk({name, " stall"}, {31'd0, stallreq_o}, 32'd0);
    chk({name, " whilo"}, {31'd0, whilo_o}, 32'd0);
    if (use_rst) begin
      chk({name, " outs"}, {wdata_o, hi_o, lo_o} == 96'd0 ? 32'd0 : 32'd1, 32'd0);
      chk({name, " wd_wreg"}, {26'd0, wd_o, wreg_o}, 32'd0);
    end
    next_cycle();
    rst     = 1'b0;
    annul_i = 1'b0;
    set_nop();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) pulses++;
      next_cycle();
    end
    chk({name, " no_pulse_after"}, pulses, 32'd0);
    run_div({name, " restart"}, 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    aluop_i  = EXE_OR_OP;
    alusel_i = EXE_RES_LOGIC;
    reg1_i   = 32'h0000_F0F0;
    reg2_i   = 32'h0000_0F0F;
    wd_i     = 5'd3;
    wreg_i   = 1'b1;
    annul_i  = 1'b0;

    vecs[0] = '{EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
    vecs[1] = '{EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
    vecs[2] = '{EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[3] = '{EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 32'hFFFF_0000};
    vecs[4] = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h0000_000F, 32'h0000_00F0};
    vecs[5] = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010};
    vecs[6] = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
    vecs[7] = '{EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000};
    vecs[8] = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h7000_0000, 32'h0700_0000};
    vecs[9] = '{EXE_OR_OP,   EXE_RES_NOP,   32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

    @(negedge clk);
    chk("reset wdata", wdata_o, 32'd0);
    chk("reset wd_wreg", {26'd0, wd_o, wreg_o}, 32'd0);
    chk("reset hilo_stall", {29'd0, whilo_o, stallreq_o, |{hi_o, lo_o}}, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      aluop_i  = vecs[i].op;
      alusel_i = vecs[i].sel;
      reg1_i   = vecs[i].a;
      reg2_i   = vecs[i].b;
      wd_i     = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp);
      chk($sformatf("vec%0d wd_wreg_stall", i), {25'd0, wd_o, wreg_o, stallreq_o},
          {25'd0, 5'(i + 1), 1'b1, 1'b0});
      next_cycle();
    end
    set_nop();
    next_cycle();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 1'b1);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);
    run_div("div_by_zero", 1'b1, 32'd1234, 32'd0, 2, 32'd0, 32'd0, 1'b0);
    run_div("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 33, 32'h5555_5555, 32'd0, 1'b0);
    @(negedge clk);
    chk("idle after div", {30'd0, whilo_o, stallreq_o}, 32'd0);
    next_cycle();

    abort_div("annul", 1'b0);
    abort_div("rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
